// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: divides clk into a 1 Hz tick, cascades sec->min->hour
// while running, and lets the user step hours then minutes in set mode.
module clock_time_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       tick,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [1:0] mode
);
    localparam int PW = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ZERO  = PW'(0);
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);
    localparam logic [5:0]    SEC_LAST  = 6'(SEC_MAX);
    localparam logic [5:0]    MIN_LAST  = 6'(MIN_MAX);
    localparam logic [4:0]    HOUR_LAST = 5'(HOUR_MAX);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } state_t;

    // Increment a 6-bit field, wrapping to zero after its terminal value.
    function automatic logic [5:0] wrap_inc6(input logic [5:0] v, input logic [5:0] last);
        logic [5:0] r;
        if (v == last) r = 6'd0;
        else           r = v + 6'd1;
        return r;
    endfunction

    // Increment a 5-bit field, wrapping to zero after its terminal value.
    function automatic logic [4:0] wrap_inc5(input logic [4:0] v, input logic [4:0] last);
        logic [4:0] r;
        if (v == last) r = 5'd0;
        else           r = v + 5'd1;
        return r;
    endfunction

    state_t          state_r, state_s;
    logic [PW-1:0]   pre_r, pre_s;
    logic [5:0]      sec_r, sec_s;
    logic [5:0]      min_r, min_s;
    logic [4:0]      hour_r, hour_s;
    logic            mode_q_r, inc_q_r;
    logic            mode_press_s, inc_press_s, tick_s;

    // A mode press wins over a simultaneous inc press.
    assign mode_press_s = btn_mode & ~mode_q_r;
    assign inc_press_s  = btn_inc & ~inc_q_r & ~mode_press_s;
    assign tick_s       = (state_r == ST_RUN) && (pre_r == PRE_LAST);

    assign tick = tick_s;
    assign sec  = sec_r;
    assign min  = min_r;
    assign hour = hour_r;
    assign mode = state_r;

    // Next-state logic: mode sequencing, prescaler, run cascade and set stepping.
    always_comb begin
        state_s = state_r;
        pre_s   = pre_r;
        sec_s   = sec_r;
        min_s   = min_r;
        hour_s  = hour_r;
        case (state_r)
            ST_RUN: begin
                if (tick_s) begin
                    pre_s = PRE_ZERO;
                    sec_s = wrap_inc6(sec_r, SEC_LAST);
                    if (sec_r == SEC_LAST) begin
                        min_s = wrap_inc6(min_r, MIN_LAST);
                        if (min_r == MIN_LAST) hour_s = wrap_inc5(hour_r, HOUR_LAST);
                        else                   hour_s = hour_r;
                    end else begin
                        min_s  = min_r;
                        hour_s = hour_r;
                    end
                end else begin
                    pre_s = pre_r + PRE_ONE;
                end
                // Any pending tick above is still applied on the leaving edge.
                if (mode_press_s) begin
                    state_s = ST_SET_HOUR;
                    pre_s   = PRE_ZERO;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_SET_HOUR: begin
                pre_s = PRE_ZERO;
                if (mode_press_s)     state_s = ST_SET_MIN;
                else if (inc_press_s) hour_s  = wrap_inc5(hour_r, HOUR_LAST);
                else                  state_s = ST_SET_HOUR;
            end
            ST_SET_MIN: begin
                pre_s = PRE_ZERO;
                if (mode_press_s) begin
                    // Restart the second cleanly so the first tick is a full period away.
                    state_s = ST_RUN;
                    sec_s   = 6'd0;
                end else if (inc_press_s) begin
                    min_s = wrap_inc6(min_r, MIN_LAST);
                end else begin
                    state_s = ST_SET_MIN;
                end
            end
            default: begin
                state_s = ST_RUN;
                pre_s   = PRE_ZERO;
            end
        endcase
    end

    // State registers; button history resets high so a held button is not a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_RUN;
            pre_r    <= PRE_ZERO;
            sec_r    <= 6'd0;
            min_r    <= 6'd0;
            hour_r   <= 5'd0;
            mode_q_r <= 1'b1;
            inc_q_r  <= 1'b1;
        end else begin
            state_r  <= state_s;
            pre_r    <= pre_s;
            sec_r    <= sec_s;
            min_r    <= min_s;
            hour_r   <= hour_s;
            mode_q_r <= btn_mode;
            inc_q_r  <= btn_inc;
        end
    end
endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: time-of-day model in seconds, directed scenarios
// with literal expectations, then randomized button/reset traffic.
module tb_clock_time_ctrl;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       tick;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;

    int total = 0;
    int bad = 0;
    int tick_cnt = 0;

    // Model: mode index, time of day in seconds, cycles since RUN entry, button history.
    int m_mode = 0;
    int m_t = 0;
    int m_run = 0;
    int pm_prev = 1;
    int pi_prev = 1;
    bit chk_en = 1'b0;

    clock_time_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .tick(tick), .sec(sec), .min(min), .hour(hour), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_run = 0; pm_prev = 1; pi_prev = 1;
    endtask

    function automatic int exp_tick();
        return (m_mode == 0 && (m_run % TD) == TD - 1) ? 1 : 0;
    endfunction

    task automatic model_step(input int bm, input int bi);
        int pm, pi, h, mi, s;
        pm = (bm != 0 && pm_prev == 0) ? 1 : 0;
        pi = (bi != 0 && pi_prev == 0 && pm == 0) ? 1 : 0;
        pm_prev = bm; pi_prev = bi;
        h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
        case (m_mode)
            0: begin
                if ((m_run % TD) == TD - 1) m_t = (m_t + 1) % 86400;
                m_run++;
                if (pm != 0) m_mode = 1;
            end
            1: begin
                if (pm != 0)      m_mode = 2;
                else if (pi != 0) m_t = ((h + 1) % 24) * 3600 + mi * 60 + s;
            end
            2: begin
                if (pm != 0) begin
                    m_mode = 0; m_t = h * 3600 + mi * 60; m_run = 0;
                end else if (pi != 0) begin
                    m_t = h * 3600 + ((mi + 1) % 60) * 60 + s;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    // One clock: drive inputs, advance the model on the edge, return at the next negedge.
    task automatic cycle(input int bm, input int bi);
        btn_mode = (bm != 0);
        btn_inc  = (bi != 0);
        @(posedge clk);
        if (reset) model_step(bm, bi);
        @(negedge clk);
        if (tick) tick_cnt++;
    endtask

    task automatic press_mode();
        cycle(1, 0); cycle(0, 0);
    endtask

    task automatic press_inc();
        cycle(0, 1); cycle(0, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sec"}, sec, 0);
        check({tag, "_min"}, min, 0);
        check({tag, "_hour"}, hour, 0);
        check({tag, "_mode"}, mode, 0);
        check({tag, "_tick"}, tick, 0);
    endtask

    // Asynchronous reset pulse: outputs must clear before any clock edge.
    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        model_reset();
        #1;
        check_zero(tag);
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    // Compare DUT against the model on every cycle the outputs are meaningful.
    always @(negedge clk) begin
        if (chk_en && reset) begin
            check("tick", tick, exp_tick());
            check("sec", sec, m_t % 60);
            check("min", min, (m_t / 60) % 60);
            check("hour", hour, m_t / 3600);
            check("mode", mode, m_mode);
        end
    end

    initial begin
        int need;
        model_reset();
        #2 reset = 1'b0;
        #1 check_zero("por");
        @(negedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        check("first_tick", tick, 0);

        // Free run from reset: ticks on cycles 3, 7, 11.
        tick_cnt = 0;
        repeat (12) cycle(0, 0);
        check("run12_ticks", tick_cnt, 3);
        check("run12_sec", sec, 3);
        check("run12_model_sec", m_t % 60, 3);

        // Hour set: 25 increments from 0 land on 1.
        press_mode();
        check("sethour_mode", mode, 1);
        tick_cnt = 0;
        repeat (25) press_inc();
        check("sethour_hour", hour, 1);
        check("sethour_min", min, 0);
        check("sethour_sec", sec, 3);
        check("sethour_noticks", tick_cnt, 0);

        // Minute set: 61 increments wrap to 1 without carrying into hour.
        press_mode();
        check("setmin_mode", mode, 2);
        repeat (61) press_inc();
        check("setmin_min", min, 1);
        check("setmin_hour", hour, 1);
        cycle(1, 0);
        check("rerun_mode", mode, 0);
        check("rerun_sec", sec, 0);
        check("rerun_tick0", tick, 0);
        cycle(0, 0);
        cycle(0, 0);
        check("rerun_tick2", tick, 0);
        cycle(0, 0);
        check("rerun_tick3", tick, 1);
        cycle(0, 0);
        check("rerun_sec1", sec, 1);
        check("rerun_tick4", tick, 0);

        // Preload 23:59 and roll over midnight.
        press_mode();
        need = (23 - m_t / 3600 + 24) % 24;
        repeat (need) press_inc();
        press_mode();
        need = (59 - (m_t / 60) % 60 + 60) % 60;
        repeat (need) press_inc();
        cycle(1, 0);
        check("pre_hour", hour, 23);
        check("pre_min", min, 59);
        check("pre_sec", sec, 0);
        tick_cnt = 0;
        repeat (236) cycle(0, 0);
        check("pre_sec59", sec, 59);
        check("pre_ticks59", tick_cnt, 59);
        repeat (4) cycle(0, 0);
        check("wrap_hour", hour, 0);
        check("wrap_min", min, 0);
        check("wrap_sec", sec, 0);
        check("wrap_ticks", tick_cnt, 60);

        // Mode and inc together: mode wins; held inc counts once.
        cycle(1, 1);
        check("both_mode", mode, 1);
        check("both_hour", hour, 0);
        cycle(0, 0);
        repeat (10) cycle(0, 1);
        cycle(0, 0);
        check("held_inc_hour", hour, 1);

        // Button held through reset release produces no press.
        @(negedge clk);
        btn_mode = 1'b1;
        reset_pulse("rst_a");
        repeat (3) cycle(1, 0);
        check("held_mode", mode, 0);
        cycle(0, 0);
        press_mode();
        press_mode();
        press_inc();
        check("pre_rst_mode", mode, 2);
        reset_pulse("rst_b");
        cycle(0, 0);
        check("post_rst_mode", mode, 0);

        // Randomized buttons with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_pulse("rst_rand");
            end else begin
                cycle(($urandom_range(0, 99) < 4) ? 1 : 0,
                      ($urandom_range(0, 99) < 35) ? 1 : 0);
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
